// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor
//   Samples a divided clock (div_in) as data in the source clock domain and
//   measures the period and high time of every divided cycle in source-clock
//   cycles. After LOCK_CNT consecutive good periods it asserts locked. Bad
//   periods and stalls are counted in err_cnt. A fault while locked also sets
//   the sticky err flag.
//
//   Build option: define CLK_MON_DUTY_CHECK_EN to make the good-period test
//   also require high_time to fall inside a window around RATIO/2. The port
//   list is the same in both builds.
//
//   Parameter constraint: 2*RATIO+TOL must be below 2**CNT_W, so that the
//   stall timeout is reachable before the period counter saturates.
module clk_ratio_monitor #(
    parameter int RATIO    = 9,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int GOOD_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TIMEOUT_LIM = CNT_W'(2 * RATIO + TOL);
    // |period - RATIO| <= TOL, rewritten as an unsigned range test.
    localparam logic [CNT_W-1:0]  PER_MIN     = (RATIO > TOL) ? CNT_W'(RATIO - TOL) : '0;
    localparam logic [CNT_W-1:0]  PER_MAX     = CNT_W'(RATIO + TOL);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,  // waiting for a first rising edge to align to
        ST_MEASURE = 2'd1,  // measuring, collecting consecutive good periods
        ST_LOCKED  = 2'd2   // ratio confirmed, any fault drops lock
    } state_e;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic              d_q;
    logic              d_qq;
    logic              rise;

    logic [CNT_W-1:0]  per_cnt_q;
    logic [CNT_W-1:0]  per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q;
    logic [CNT_W-1:0]  hi_cnt_d;

    state_e            state_q;
    logic [GOOD_W-1:0] good_cnt_q;
    logic [GOOD_W-1:0] good_cnt_inc;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  high_q;
    logic              meas_valid_q;
    logic              locked_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;
    logic [7:0]        err_cnt_inc;

    logic              per_ok;
    logic              duty_ok;
    logic              period_good;
    logic              timeout;

    // ------------------------------------------------------------------
    // Input sampling: two flops give the current and previous level of
    // div_in so that a rising edge is seen as one-cycle pulse.
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (d_qq takes the old d_q).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= 1'b0;
            d_qq <= 1'b0;
        end else begin
            d_q  <= div_in;
            d_qq <= d_q;
        end
    end

    assign rise = d_q & ~d_qq;

    // ------------------------------------------------------------------
    // Next value of the period and high-time counters. Both restart at 1 on
    // a rise because the cycle that carries the rise is already part of the
    // new divided period (and it is a high cycle).
    // ------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + CNT_ONE;
            end
            if (d_q && (hi_cnt_q != CNT_MAX)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
        end
    end

    // Period and high-time counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Period qualification. The counters hold the length of the period that
    // just ended during the cycle in which the next rise is seen.
    // ------------------------------------------------------------------
    assign per_ok = (per_cnt_q >= PER_MIN) && (per_cnt_q <= PER_MAX);

`ifdef CLK_MON_DUTY_CHECK_EN
    // Integer-division window: RATIO=9, TOL=0 accepts high times 4 and 5,
    // which covers both phases of a dual-edge 50% divider output.
    localparam logic [CNT_W-1:0] HI_MIN = (RATIO / 2 > TOL) ? CNT_W'(RATIO / 2 - TOL) : '0;
    localparam logic [CNT_W-1:0] HI_MAX = CNT_W'((RATIO + 1) / 2 + TOL);

    assign duty_ok = (hi_cnt_q >= HI_MIN) && (hi_cnt_q <= HI_MAX);
`else
    // High time is still reported, it just never disqualifies a period.
    assign duty_ok = 1'b1;
`endif

    assign period_good = per_ok && duty_ok;

    // A stall only counts while aligned; a rise in the same cycle wins.
    assign timeout = (state_q != ST_SYNC) && !rise && (per_cnt_q >= TIMEOUT_LIM);

    assign good_cnt_inc = good_cnt_q + GOOD_W'(1);
    assign err_cnt_inc  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // ------------------------------------------------------------------
    // Lock state machine with registered measurement and status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            good_cnt_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            meas_valid_q <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    // The first rise only aligns the counters; the partial
                    // period before it is meaningless and is not captured.
                    if (rise) begin
                        state_q    <= ST_MEASURE;
                        good_cnt_q <= '0;
                    end
                end

                ST_MEASURE: begin
                    if (rise) begin
                        period_q     <= per_cnt_q;
                        high_q       <= hi_cnt_q;
                        meas_valid_q <= 1'b1;
                        if (period_good) begin
                            good_cnt_q <= good_cnt_inc;
                            if (good_cnt_inc == GOOD_TARGET) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            good_cnt_q <= '0;
                            err_cnt_q  <= err_cnt_inc;
                        end
                    end else if (timeout) begin
                        err_cnt_q <= err_cnt_inc;
                        state_q   <= ST_SYNC;
                    end
                end

                ST_LOCKED: begin
                    if (rise) begin
                        period_q     <= per_cnt_q;
                        high_q       <= hi_cnt_q;
                        meas_valid_q <= 1'b1;
                        if (!period_good) begin
                            locked_q   <= 1'b0;
                            err_q      <= 1'b1;
                            err_cnt_q  <= err_cnt_inc;
                            good_cnt_q <= '0;
                            state_q    <= ST_MEASURE;
                        end
                    end else if (timeout) begin
                        locked_q  <= 1'b0;
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_inc;
                        state_q   <= ST_SYNC;
                    end
                end

                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor. Two instances share clk, rst and div_in:
// dut 0 uses TOL=0, dut 1 uses TOL=1. A history-based reference model
// derives every expected output each cycle, and directed phases pin the
// model with literal expectations (lock point, timeout distance, counts).
// Expectations follow CLK_MON_DUTY_CHECK_EN when the bench is built with it.
module tb_clk_ratio_monitor;

    localparam int RATIO     = 9;
    localparam int LOCK_CNT  = 4;
    localparam int N_DUT     = 2;
    localparam int MAX_EDGES = 8192;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_in;

    logic [7:0] period_o  [N_DUT];
    logic [7:0] high_o    [N_DUT];
    logic       valid_o   [N_DUT];
    logic       locked_o  [N_DUT];
    logic       err_o     [N_DUT];
    logic [7:0] errcnt_o  [N_DUT];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clk_ratio_monitor #(.RATIO(RATIO), .TOL(0), .LOCK_CNT(LOCK_CNT), .CNT_W(8)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .period     (period_o[0]),
        .high_time  (high_o[0]),
        .meas_valid (valid_o[0]),
        .locked     (locked_o[0]),
        .err        (err_o[0]),
        .err_cnt    (errcnt_o[0])
    );

    clk_ratio_monitor #(.RATIO(RATIO), .TOL(1), .LOCK_CNT(LOCK_CNT), .CNT_W(8)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .div_in     (div_in),
        .period     (period_o[1]),
        .high_time  (high_o[1]),
        .meas_valid (valid_o[1]),
        .locked     (locked_o[1]),
        .err        (err_o[1]),
        .err_cnt    (errcnt_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Works from the history of sampled div_in levels:
    // a rise is a 0->1 step in that history, a period is the distance in
    // edges between two rises, high time is the number of high samples
    // within that period.
    // ------------------------------------------------------------------
    typedef enum {M_SYNC, M_HUNT, M_LOCK} mode_e;

    logic  hist [MAX_EDGES];
    int    edge_n = -1;
    logic  samp_div;
    logic  samp_rst;

    mode_e m_mode   [N_DUT];
    int    m_last   [N_DUT];
    int    m_good   [N_DUT];
    int    m_per    [N_DUT];
    int    m_high   [N_DUT];
    int    m_errcnt [N_DUT];
    bit    m_valid  [N_DUT];
    bit    m_locked [N_DUT];
    bit    m_err    [N_DUT];

    // Observed-behaviour bookkeeping used by the literal checks.
    int    since_drop  [N_DUT];
    int    lock_after  [N_DUT];
    int    to_gap      [N_DUT];
    int    last_valid  [N_DUT];
    logic  prev_locked [N_DUT];
    logic [7:0] prev_errcnt [N_DUT];

    function automatic int tol_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    task automatic bump_err(input int i);
        if (m_errcnt[i] < 255) m_errcnt[i]++;
    endtask

    task automatic model_step(input int i);
        int tol;
        int p;
        int h;
        bit is_rise;
        bit ok;
        tol        = tol_of(i);
        m_valid[i] = 1'b0;
        if (samp_rst) begin
            m_mode[i]   = M_SYNC;
            m_good[i]   = 0;
            m_per[i]    = 0;
            m_high[i]   = 0;
            m_errcnt[i] = 0;
            m_locked[i] = 1'b0;
            m_err[i]    = 1'b0;
            return;
        end
        is_rise = (edge_n >= 2) && hist[edge_n-1] && !hist[edge_n-2];
        if (is_rise) begin
            if (m_mode[i] == M_SYNC) begin
                m_mode[i] = M_HUNT;
                m_good[i] = 0;
            end else begin
                p = edge_n - m_last[i];
                h = 0;
                for (int j = m_last[i] - 1; j <= edge_n - 2; j++) h += int'(hist[j]);
                m_per[i]   = p;
                m_high[i]  = h;
                m_valid[i] = 1'b1;
                ok = (p - RATIO <= tol) && (RATIO - p <= tol);
`ifdef CLK_MON_DUTY_CHECK_EN
                ok = ok && (h >= RATIO / 2 - tol) && (h <= (RATIO + 1) / 2 + tol);
`endif
                if (m_mode[i] == M_HUNT) begin
                    if (ok) begin
                        m_good[i]++;
                        if (m_good[i] == LOCK_CNT) begin
                            m_mode[i]   = M_LOCK;
                            m_locked[i] = 1'b1;
                        end
                    end else begin
                        m_good[i] = 0;
                        bump_err(i);
                    end
                end else if (!ok) begin
                    m_locked[i] = 1'b0;
                    m_err[i]    = 1'b1;
                    m_mode[i]   = M_HUNT;
                    m_good[i]   = 0;
                    bump_err(i);
                end
            end
            m_last[i] = edge_n;
        end else if (m_mode[i] != M_SYNC && edge_n - m_last[i] >= 2 * RATIO + tol) begin
            bump_err(i);
            if (m_mode[i] == M_LOCK) begin
                m_err[i]    = 1'b1;
                m_locked[i] = 1'b0;
            end
            m_mode[i] = M_SYNC;
        end
    endtask

    // Snapshot the inputs exactly as the DUT sees them on the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            samp_div = div_in;
            samp_rst = rst;
        end
    end

    // Compare process: advance the model by one edge, then check every
    // output of both instances.
    initial begin
        for (int i = 0; i < N_DUT; i++) begin
            lock_after[i] = -1;
            to_gap[i]     = -1;
            last_valid[i] = 0;
            since_drop[i] = 0;
        end
        forever begin
            @(negedge clk);
            edge_n++;
            if (edge_n >= MAX_EDGES) begin
                $display("FAIL edge budget: got %0d edges, expected below %0d", edge_n, MAX_EDGES);
                $fatal(1, "history overflow");
            end
            hist[edge_n] = samp_rst ? 1'b0 : samp_div;
            for (int i = 0; i < N_DUT; i++) begin
                model_step(i);
                check($sformatf("dut%0d period", i),     period_o[i], m_per[i]);
                check($sformatf("dut%0d high_time", i),  high_o[i],   m_high[i]);
                check($sformatf("dut%0d meas_valid", i), valid_o[i],  m_valid[i]);
                check($sformatf("dut%0d locked", i),     locked_o[i], m_locked[i]);
                check($sformatf("dut%0d err", i),        err_o[i],    m_err[i]);
                check($sformatf("dut%0d err_cnt", i),    errcnt_o[i], m_errcnt[i]);
                if (samp_rst) begin
                    since_drop[i] = 0;
                end else begin
                    if (valid_o[i] === 1'b1) since_drop[i]++;
                    if (prev_locked[i] === 1'b1 && locked_o[i] === 1'b0) since_drop[i] = 0;
                    if (prev_locked[i] === 1'b0 && locked_o[i] === 1'b1) lock_after[i] = since_drop[i];
                    if (errcnt_o[i] !== prev_errcnt[i] && valid_o[i] !== 1'b1)
                        to_gap[i] = edge_n - last_valid[i];
                    if (valid_o[i] === 1'b1) last_valid[i] = edge_n;
                end
                prev_locked[i] = locked_o[i];
                prev_errcnt[i] = errcnt_o[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic gen(input int hi, input int lo);
        div_in = 1'b1;
        repeat (hi) @(negedge clk);
        div_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Divide-by-9 with a dual-edge 50% duty shape: high 5/4 alternately.
    task automatic gen_div9(input int n);
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) gen(5, 4);
            else            gen(4, 5);
        end
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("rst dut%0d period", i),     period_o[i], 0);
            check($sformatf("rst dut%0d high_time", i),  high_o[i],   0);
            check($sformatf("rst dut%0d meas_valid", i), valid_o[i],  0);
            check($sformatf("rst dut%0d locked", i),     locked_o[i], 0);
            check($sformatf("rst dut%0d err", i),        err_o[i],    0);
            check($sformatf("rst dut%0d err_cnt", i),    errcnt_o[i], 0);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
    endtask

    task automatic expect_status(input int i, input int lk, input int er, input int cnt, input string tag);
        check($sformatf("%s dut%0d locked", tag, i),  locked_o[i], lk);
        check($sformatf("%s dut%0d err", tag, i),     err_o[i],    er);
        check($sformatf("%s dut%0d err_cnt", tag, i), errcnt_o[i], cnt);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got no end of run, expected completion within 100 us");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed phases
    // ------------------------------------------------------------------
    initial begin
        rst    = 1'b1;
        div_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;

        // Lock on a divide-by-9 source: sync rise + 4 good measurements.
        gen_div9(8);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            expect_status(i, 1, 0, 0, "lock");
            check($sformatf("lock dut%0d lock_after", i), lock_after[i], 4);
        end

        // One period stretched to 10: fault for TOL=0 only, then relock.
        gen(5, 5);
        gen_div9(6);
        #1;
        expect_status(0, 1, 1, 1, "bad10");
        check("bad10 dut0 lock_after", lock_after[0], 4);
        expect_status(1, 1, 0, 0, "bad10");

        // Stall: low for 25 cycles; timeout 2*RATIO+TOL edges after last capture.
        gen(4, 25);
        #1;
        expect_status(0, 0, 1, 2, "stall");
        expect_status(1, 0, 1, 1, "stall");
        check("stall dut0 to_gap", to_gap[0], 18);
        check("stall dut1 to_gap", to_gap[1], 19);

        // Resume: sync rise + 4 good measurements before lock returns.
        gen_div9(6);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("resume dut%0d locked", i), locked_o[i], 1);
            check($sformatf("resume dut%0d lock_after", i), lock_after[i], 4);
        end

        // A second stretched period brings dut0 to err_cnt = 3.
        gen(5, 5);
        gen_div9(6);
        #1;
        expect_status(0, 1, 1, 3, "bad10b");
        expect_status(1, 1, 1, 1, "bad10b");

        // Reset mid-run while locked, then a normal relock.
        pulse_reset();
        gen_div9(6);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            expect_status(i, 1, 0, 0, "relock");
            check($sformatf("relock dut%0d lock_after", i), lock_after[i], 4);
        end

        // Narrow pulse: high 2, low 7. Period is right, duty is not.
        pulse_reset();
        for (int k = 0; k < 6; k++) gen(2, 7);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("duty dut%0d period", i), period_o[i], 9);
            check($sformatf("duty dut%0d high_time", i), high_o[i], 2);
`ifdef CLK_MON_DUTY_CHECK_EN
            expect_status(i, 0, 0, 5, "duty");
`else
            expect_status(i, 1, 0, 0, "duty");
`endif
        end

        // Tolerance: periods alternate 8/10, then 9, 11, 9.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            gen(4, 4);
            gen(5, 5);
        end
        gen(5, 4);
        gen(5, 6);
        gen(5, 4);
        #1;
        expect_status(0, 0, 0, 9, "tol");
        expect_status(1, 0, 1, 1, "tol");
        check("tol dut1 lock_after", lock_after[1], 4);
        check("tol dut1 period", period_o[1], 11);

        // Idle tail lets the final stall timeouts play out under the model.
        repeat (30) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
